// File: rtl/rob_alloc_if.sv
// Dispatch-side bundle between the dispatch stage and the ROB entry allocator.
interface rob_alloc_if #(
    parameter int ENTRY_SEL = 6
);
    logic [1:0]           req_num_i;
    logic                 stall_i;
    logic [1:0]           commit_num_i;
    logic [ENTRY_SEL-1:0] commit_ptr_i;
    logic                 flush_i;
    logic                 dp1_o;
    logic [ENTRY_SEL-1:0] dp1_addr_o;
    logic                 dp2_o;
    logic [ENTRY_SEL-1:0] dp2_addr_o;
    logic                 allocatable_o;
    logic [ENTRY_SEL:0]   freenum_o;
    logic                 full_o;
    logic                 empty_o;

    modport master (
        output req_num_i, stall_i, commit_num_i, commit_ptr_i, flush_i,
        input  dp1_o, dp1_addr_o, dp2_o, dp2_addr_o, allocatable_o,
               freenum_o, full_o, empty_o
    );

    modport slave (
        input  req_num_i, stall_i, commit_num_i, commit_ptr_i, flush_i,
        output dp1_o, dp1_addr_o, dp2_o, dp2_addr_o, allocatable_o,
               freenum_o, full_o, empty_o
    );
endinterface

// File: rtl/rob_alloc.sv
// ROB entry allocator: grants up to two consecutive slots per cycle, tracks tail and free count.
// Define ROB_ALLOC_BYPASS_EN to let this cycle's commits count toward allocatable entries.
module rob_alloc #(
    parameter int ENTRY_NUM = 64,
    parameter int ENTRY_SEL = 6
) (
    input logic        clk,
    input logic        reset,
    rob_alloc_if.slave bus
);
    localparam logic [ENTRY_SEL:0] FREE_MAX = (ENTRY_SEL+1)'(ENTRY_NUM);

    logic [ENTRY_SEL-1:0] tail_ptr;
    logic [ENTRY_SEL:0]   freenum;
    logic [ENTRY_SEL:0]   avail;
    logic [ENTRY_SEL:0]   commit_ext;
    logic [ENTRY_SEL:0]   alloc_ext;
    logic [ENTRY_SEL:0]   req_ext;
    logic [1:0]           req_eff;
    logic [1:0]           alloc_num;
    logic                 allocatable;
    logic                 grant;
    logic                 dp1;
    logic                 dp2;

    always_comb begin
        // An illegal request of 3 is handled as no request.
        req_eff     = (bus.req_num_i == 2'd3) ? 2'd0 : bus.req_num_i;
        req_ext     = {{(ENTRY_SEL-1){1'b0}}, req_eff};
        commit_ext  = {{(ENTRY_SEL-1){1'b0}}, bus.commit_num_i};
`ifdef ROB_ALLOC_BYPASS_EN
        avail       = freenum + commit_ext;
`else
        avail       = freenum;
`endif
        allocatable = (avail >= req_ext);
        grant       = allocatable && !bus.stall_i && !bus.flush_i && !reset;
        dp1         = grant && (req_eff >= 2'd1);
        dp2         = grant && (req_eff == 2'd2);
        alloc_num   = {1'b0, dp1} + {1'b0, dp2};
        alloc_ext   = {{(ENTRY_SEL-1){1'b0}}, alloc_num};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tail_ptr <= '0;
            freenum  <= FREE_MAX;
        end else if (bus.flush_i) begin
            tail_ptr <= bus.commit_ptr_i + ENTRY_SEL'(bus.commit_num_i);
            freenum  <= FREE_MAX;
        end else begin
            tail_ptr <= tail_ptr + ENTRY_SEL'(alloc_num);
            freenum  <= freenum + commit_ext - alloc_ext;
        end
    end

    assign bus.dp1_o         = dp1;
    assign bus.dp2_o         = dp2;
    assign bus.dp1_addr_o    = tail_ptr;
    assign bus.dp2_addr_o    = tail_ptr + ENTRY_SEL'(1);
    assign bus.allocatable_o = allocatable;
    assign bus.freenum_o     = freenum;
    assign bus.full_o        = (freenum == '0);
    assign bus.empty_o       = (freenum == FREE_MAX);
endmodule
